pipe_hazard_sequencer: RTL and testbench

Multi-cycle pipeline control sequencer for the MINI-RISC 3-stage pipeline (F/D/E, plus W writeback register). It arbitrates stall and flush requests from the control unit and hazard detection, then drives stall_*/flush_* to the FD/DE/EW registers, plus pc_sel and alu_en. It replaces single-cycle combinational branch control with a counted FSM. This gives deterministic branch penalties, flag-wait interlocks and load-use stalls.

---
 rtl/pipe_hazard_sequencer_pkg.sv | 33 +++
 rtl/pipe_hazard_sequencer_down_counter.sv | 34 +++
 rtl/pipe_hazard_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_hazard_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_sequencer_pkg.sv
// Shared definitions for the MINI-RISC pipeline hazard sequencer.
// Contents: FSM state encodings, the counter width, default parameter values
// and small helpers for parameter range checking and counter preload values.
package pipe_hazard_sequencer_pkg;

  // One counter serves every non-IDLE state, so its width bounds all penalties.
  localparam int CNT_W = 3;

  // Default timing parameters.
  localparam int BR_PENALTY_DEF      = 2;
  localparam int LD_STALL_CYCLES_DEF = 1;
  localparam int FLAG_WAIT_MAX_DEF   = 3;

  // Debug-visible state encodings. They appear on state_dbg, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FLAG_WAIT = 2'd1,
    ST_BR_FLUSH  = 2'd2,
    ST_LD_STALL  = 2'd3
  } hzd_state_t;

  // The IDLE cycle that accepts a request is the first cycle of the sequence.
  // The counter therefore preloads one less than the total cycle count.
  function automatic logic [CNT_W-1:0] cnt_init(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

  // Every count must fit in CNT_W bits and must be at least one cycle.
  function automatic bit param_ok(input int p);
    return (p >= 1) && (p <= 7);
  endfunction

endpackage

// File: rtl/pipe_hazard_sequencer_down_counter.sv
// hzd_down_counter: loadable down-counter shared by the sequencer states.
// Latency: load and decrement take effect on the next clk edge; o_zero is combinational from the count.
// Backpressure: none; decrement saturates at zero, so the counter never underflows.
// Ports: clk/rst (async, active-high); i_load/i_load_val preload the count;
//        i_dec decrements; o_cnt is the current count; o_zero flags a count of 0.
module hzd_down_counter
  import pipe_hazard_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority over decrement. Only one of them is ever requested at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// pipe_hazard_sequencer: stall/flush/redirect control for the MINI-RISC F/D/E(+W) pipeline.
// Latency: responds in the same cycle as a request from IDLE (Mealy outputs). Outputs in other states are Moore.
// Backpressure: branch_req/jump_req are levels held until branch_ack. Requests are ignored during BR_FLUSH.
// Ports: clk, rst (async, active-high); requests branch_req, jump_req, flag_pending,
//        load_use_req; controls stall_F/D/E, flush_F/D/E, pc_sel, alu_en; status branch_ack,
//        busy, state_dbg.
// Optional: define HZD_PERF_EN to add the saturating counters perf_stall_cyc,
//           perf_flush_cyc and perf_branch_cnt.
module pipe_hazard_sequencer
  import pipe_hazard_sequencer_pkg::*;
#(
  parameter int BR_PENALTY      = BR_PENALTY_DEF,
  parameter int LD_STALL_CYCLES = LD_STALL_CYCLES_DEF,
  parameter int FLAG_WAIT_MAX   = FLAG_WAIT_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_req,
  input  logic        jump_req,
  input  logic        flag_pending,
  input  logic        load_use_req,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        flush_F,
  output logic        flush_D,
  output logic        flush_E,
  output logic        pc_sel,
  output logic        alu_en,
  output logic        branch_ack,
  output logic        busy,
  output logic [1:0]  state_dbg
`ifdef HZD_PERF_EN
  ,
  output logic [15:0] perf_stall_cyc,
  output logic [15:0] perf_flush_cyc,
  output logic [15:0] perf_branch_cnt
`endif
);

  // Parameters beyond the counter range would silently truncate, so reject them at elaboration.
  if (!param_ok(BR_PENALTY)) begin : g_bad_br_penalty
    $error("BR_PENALTY must be in 1..7");
  end
  if (!param_ok(LD_STALL_CYCLES)) begin : g_bad_ld_stall
    $error("LD_STALL_CYCLES must be in 1..7");
  end
  if (!param_ok(FLAG_WAIT_MAX)) begin : g_bad_flag_wait
    $error("FLAG_WAIT_MAX must be in 1..7");
  end

  hzd_state_t       r_state;
  hzd_state_t       w_state_nxt;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;
  logic             w_cnt_last;

  hzd_down_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // A count of 1 is the final cycle of a counted sequence.
  // The test also matches 0, so a sequence can never wait on a counter that cannot move.
  assign w_cnt_last = (w_cnt <= CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_dec      = 1'b0;
    stall_F        = 1'b0;
    stall_D        = 1'b0;
    stall_E        = 1'b0;
    flush_F        = 1'b0;
    flush_D        = 1'b0;
    flush_E        = 1'b0;
    pc_sel         = 1'b0;
    alu_en         = 1'b1;
    branch_ack     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (branch_req || jump_req) begin
          if (jump_req || !flag_pending) begin
            // Redirect now. FD and DE are cleared because both hold wrong-path instructions.
            pc_sel     = 1'b1;
            branch_ack = 1'b1;
            flush_F    = 1'b1;
            flush_D    = 1'b1;
            if (BR_PENALTY > 1) begin
              w_state_nxt    = ST_BR_FLUSH;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = cnt_init(BR_PENALTY);
            end
          end else begin
            // Flags from SETF/CPLF in W are not valid yet, so freeze the pipe until they retire.
            stall_F        = 1'b1;
            stall_D        = 1'b1;
            stall_E        = 1'b1;
            alu_en         = 1'b0;
            w_state_nxt    = ST_FLAG_WAIT;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = cnt_init(FLAG_WAIT_MAX);
          end
        end else if (load_use_req) begin
          // Hold F/D and send a bubble into E until the load data can be forwarded.
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
          alu_en  = 1'b0;
          if (LD_STALL_CYCLES > 1) begin
            w_state_nxt    = ST_LD_STALL;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = cnt_init(LD_STALL_CYCLES);
          end
        end
      end

      ST_FLAG_WAIT: begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        alu_en  = 1'b0;
        // A squashed branch, retired flags or an expired wait all hand control back to IDLE.
        // IDLE then re-evaluates any branch that is still requested.
        if (!branch_req || !flag_pending || w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end

      ST_BR_FLUSH: begin
        flush_D   = 1'b1;
        alu_en    = 1'b0;
        w_cnt_dec = 1'b1;
        if (w_cnt_last) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_LD_STALL: begin
        stall_F   = 1'b1;
        stall_D   = 1'b1;
        flush_E   = 1'b1;
        alu_en    = 1'b0;
        w_cnt_dec = 1'b1;
        if (w_cnt_last) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign state_dbg = r_state;

`ifdef HZD_PERF_EN
  logic [15:0] r_perf_stall;
  logic [15:0] r_perf_flush;
  logic [15:0] r_perf_branch;
  logic        w_any_stall;
  logic        w_any_flush;

  assign w_any_stall = stall_F | stall_D | stall_E;
  assign w_any_flush = flush_F | flush_D | flush_E;

  // The counters saturate at all-ones, so a long run never wraps to a misleading small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall  <= '0;
      r_perf_flush  <= '0;
      r_perf_branch <= '0;
    end else begin
      if (w_any_stall && (r_perf_stall != 16'hFFFF)) begin
        r_perf_stall <= r_perf_stall + 16'd1;
      end
      if (w_any_flush && (r_perf_flush != 16'hFFFF)) begin
        r_perf_flush <= r_perf_flush + 16'd1;
      end
      if (branch_ack && (r_perf_branch != 16'hFFFF)) begin
        r_perf_branch <= r_perf_branch + 16'd1;
      end
    end
  end

  assign perf_stall_cyc  = r_perf_stall;
  assign perf_flush_cyc  = r_perf_flush;
  assign perf_branch_cnt = r_perf_branch;
`endif

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed-vector bench for pipe_hazard_sequencer (BR_PENALTY=2, LD_STALL_CYCLES=2, FLAG_WAIT_MAX=3).
// Inputs change just after each rising edge. Outputs are sampled on the falling edge.
// The observed output word is {stall_F,stall_D,stall_E,flush_F,flush_D,flush_E,pc_sel,alu_en,branch_ack,busy,state_dbg}.
module tb_pipe_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       branch_req;
  logic       jump_req;
  logic       flag_pending;
  logic       load_use_req;
  logic       stall_F, stall_D, stall_E;
  logic       flush_F, flush_D, flush_E;
  logic       pc_sel, alu_en, branch_ack, busy;
  logic [1:0] state_dbg;
`ifdef HZD_PERF_EN
  logic [15:0] perf_stall_cyc, perf_flush_cyc, perf_branch_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_sequencer #(
    .BR_PENALTY      (2),
    .LD_STALL_CYCLES (2),
    .FLAG_WAIT_MAX   (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_req   (branch_req),
    .jump_req     (jump_req),
    .flag_pending (flag_pending),
    .load_use_req (load_use_req),
    .stall_F      (stall_F),
    .stall_D      (stall_D),
    .stall_E      (stall_E),
    .flush_F      (flush_F),
    .flush_D      (flush_D),
    .flush_E      (flush_E),
    .pc_sel       (pc_sel),
    .alu_en       (alu_en),
    .branch_ack   (branch_ack),
    .busy         (busy),
    .state_dbg    (state_dbg)
`ifdef HZD_PERF_EN
    ,
    .perf_stall_cyc  (perf_stall_cyc),
    .perf_flush_cyc  (perf_flush_cyc),
    .perf_branch_cnt (perf_branch_cnt)
`endif
  );

  logic [11:0] w_obs;
  assign w_obs = {stall_F, stall_D, stall_E, flush_F, flush_D, flush_E,
                  pc_sel, alu_en, branch_ack, busy, state_dbg};

  function automatic logic [11:0] ov(input logic sf, sd, se, ff, fd, fe, pc, alu, ack, bsy,
                                     input logic [1:0] st);
    return {sf, sd, se, ff, fd, fe, pc, alu, ack, bsy, st};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check the outputs mid-cycle, then advance past the next edge.
  task automatic cyc(input logic br, input logic jr, input logic fp, input logic lu,
                     input string tag, input logic [11:0] exp);
    branch_req   = br;
    jump_req     = jr;
    flag_pending = fp;
    load_use_req = lu;
    @(negedge clk);
    chk(tag, {4'h0, w_obs}, {4'h0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [11:0] e_idle, e_redir, e_fw_in, e_fw, e_brf, e_ld_in, e_ld;

  initial begin
    e_idle  = ov(0,0,0, 0,0,0, 0,1,0,0, 2'd0);
    e_redir = ov(0,0,0, 1,1,0, 1,1,1,0, 2'd0);
    e_fw_in = ov(1,1,1, 0,0,0, 0,0,0,0, 2'd0);
    e_fw    = ov(1,1,1, 0,0,0, 0,0,0,1, 2'd1);
    e_brf   = ov(0,0,0, 0,1,0, 0,0,0,1, 2'd2);
    e_ld_in = ov(1,1,0, 0,0,1, 0,0,0,0, 2'd0);
    e_ld    = ov(1,1,0, 0,0,1, 0,0,0,1, 2'd3);

    rst = 1'b1;
    branch_req = 1'b0; jump_req = 1'b0; flag_pending = 1'b0; load_use_req = 1'b0;
    #2;
    chk("reset_outputs", {4'h0, w_obs}, {4'h0, e_idle});
    @(posedge clk); #1;
    rst = 1'b0;

    // Jump: redirect, then one extra decode flush, then back to idle.
    cyc(0,1,0,0, "jump_redirect", e_redir);
    cyc(0,0,0,0, "jump_brflush",  e_brf);
    cyc(0,0,0,0, "jump_idle",     e_idle);

    // Taken branch with flags already valid behaves like a jump.
    cyc(1,0,0,0, "br_direct",       e_redir);
    cyc(0,0,0,0, "br_direct_flush", e_brf);
    cyc(0,0,0,0, "br_direct_idle",  e_idle);

    // Flags pending for 2 cycles: FLAG_WAIT for cycles 1-2, redirect in cycle 3.
    cyc(1,0,1,0, "fw_enter",    e_fw_in);
    cyc(1,0,1,0, "fw_wait1",    e_fw);
    cyc(1,0,0,0, "fw_wait2",    e_fw);
    cyc(1,0,0,0, "fw_ack",      e_redir);
    cyc(0,0,0,0, "fw_ack_flush", e_brf);
    cyc(0,0,0,0, "fw_ack_idle",  e_idle);

    // Flags stuck: 3 FLAG_WAIT cycles, then a forced return to IDLE.
    cyc(1,0,1,0, "stuck_enter", e_fw_in);
    cyc(1,0,1,0, "stuck_st1a",  e_fw);
    cyc(1,0,1,0, "stuck_st1b",  e_fw);
    cyc(1,0,1,0, "stuck_st1c",  e_fw);
    cyc(0,0,1,0, "stuck_idle",  e_idle);

    // A branch squashed while waiting returns to IDLE without an ack.
    cyc(1,0,1,0, "squash_enter", e_fw_in);
    cyc(0,0,1,0, "squash_wait",  e_fw);
    cyc(0,0,0,0, "squash_idle",  e_idle);

    // Jump beats load-use. Load-use is ignored in BR_FLUSH and then served in IDLE for 2 cycles.
    cyc(0,1,0,1, "prio_jump",     e_redir);
    cyc(0,0,0,1, "prio_brflush",  e_brf);
    cyc(0,0,0,1, "ld_enter",      e_ld_in);
    cyc(0,0,0,0, "ld_stall",      e_ld);
    cyc(0,0,0,0, "ld_idle",       e_idle);

    // Asynchronous reset in the middle of BR_FLUSH clears the outputs at once.
    cyc(0,1,0,0, "rst_jump", e_redir);
    branch_req = 1'b0; jump_req = 1'b0; flag_pending = 1'b0; load_use_req = 1'b0;
    @(negedge clk);
    chk("rst_pre_brflush", {4'h0, w_obs}, {4'h0, e_brf});
    #1 rst = 1'b1;
    #1 chk("rst_async", {4'h0, w_obs}, {4'h0, e_idle});
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0,0,0,0, "rst_post_idle", e_idle);

`ifdef HZD_PERF_EN
    for (int i = 0; i < 3; i++) begin
      cyc(0,1,0,0, "perf_jump",  e_redir);
      cyc(0,0,0,0, "perf_flush", e_brf);
    end
    chk("perf_branch_cnt", perf_branch_cnt, 16'd3);
    chk("perf_flush_cyc",  perf_flush_cyc,  16'd6);
    chk("perf_stall_cyc",  perf_stall_cyc,  16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
